// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
package mult_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        RUN  = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } state_t;

    localparam int SIGN_BIT = 1;

    // Iteration counter width; never narrower than one bit.
    function automatic int cnt_width(input int width, input int bpc);
        int n;
        n = width / bpc;
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mult_step.sv
// One RUN cycle of the multiplier: BITS_PER_CYCLE conditional-add / shift-right steps, LSB first.
module mult_step #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic [2*WIDTH-1:0]        acc_i,
    input  logic [WIDTH-1:0]          a_i,
    input  logic [BITS_PER_CYCLE-1:0] bits_i,
    output logic [2*WIDTH-1:0]        acc_o
);

    logic [WIDTH:0] sum;

    always_comb begin
        sum   = '0;
        acc_o = acc_i;
        for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
            // Carry out of the upper half lands in the MSB after the shift.
            sum   = {1'b0, acc_o[2*WIDTH-1:WIDTH]} + (bits_i[i] ? {1'b0, a_i} : '0);
            acc_o = {sum, acc_o[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mult_seq.sv
// Multi-cycle signed/unsigned integer multiplier with start/busy/done handshake.
// Signed operands are multiplied as magnitudes and the sign is restored in FIX.
module mult_seq
    import mult_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       sign,
    input  logic [WIDTH-1:0] multiplier,
    input  logic [WIDTH-1:0] multiplicand,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] productHI,
    output logic [WIDTH-1:0] productLO
);

    localparam int N  = WIDTH / BITS_PER_CYCLE;
    localparam int CW = cnt_width(WIDTH, BITS_PER_CYCLE);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic               sgn_q, sgn_d;
    logic               neg_q, neg_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic [2*WIDTH-1:0] acc_step;
    logic [2*WIDTH-1:0] acc_fix;
    logic               accept;
    logic               sign_unused;

    assign sign_unused = sign[0];

    mult_step #(
        .WIDTH          (WIDTH),
        .BITS_PER_CYCLE (BITS_PER_CYCLE)
    ) u_step (
        .acc_i  (acc_q),
        .a_i    (a_q),
        .bits_i (b_q[BITS_PER_CYCLE-1:0]),
        .acc_o  (acc_step)
    );

    assign accept  = start && (state_q == IDLE || state_q == DONE);
    assign acc_fix = neg_q ? -acc_q : acc_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        sgn_d   = sgn_q;
        neg_d   = neg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    a_d     = multiplicand;
                    b_d     = multiplier;
                    sgn_d   = sign[SIGN_BIT];
                    state_d = LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD: begin
                if (sgn_q && a_q[WIDTH-1]) a_d = -a_q;
                if (sgn_q && b_q[WIDTH-1]) b_d = -b_q;
                neg_d   = sgn_q & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
                acc_d   = '0;
                cnt_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                acc_d = acc_step;
                b_d   = b_q >> BITS_PER_CYCLE;
                if (cnt_q == LAST) begin
                    state_d = FIX;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            FIX: begin
                acc_d   = acc_fix;
                hi_d    = acc_fix[2*WIDTH-1:WIDTH];
                lo_d    = acc_fix[WIDTH-1:0];
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            sgn_q   <= 1'b0;
            neg_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            sgn_q   <= sgn_d;
            neg_q   <= neg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy      = (state_q == LOAD) || (state_q == RUN) || (state_q == FIX);
    assign done      = (state_q == DONE);
    assign productHI = hi_q;
    assign productLO = lo_q;

endmodule

// File: tb/tb_mult_seq.sv
// Self-checking bench for mult_seq: per-cycle reference model plus directed literal cases.
module tb_mult_seq;

    localparam int W  = 32;
    localparam int N1 = 32;
    localparam int N4 = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          start, start4;
    logic [1:0]    sign, sign4;
    logic [W-1:0]  multiplier, multiplicand, multiplier4, multiplicand4;
    logic          busy, done, busy4, done4;
    logic [W-1:0]  productHI, productLO, productHI4, productLO4;

    int errors = 0;
    int checks = 0;

    mult_seq #(.WIDTH(W), .BITS_PER_CYCLE(1)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .sign         (sign),
        .multiplier   (multiplier),
        .multiplicand (multiplicand),
        .busy         (busy),
        .done         (done),
        .productHI    (productHI),
        .productLO    (productLO)
    );

    mult_seq #(.WIDTH(W), .BITS_PER_CYCLE(4)) dut4 (
        .clk          (clk),
        .reset        (reset),
        .start        (start4),
        .sign         (sign4),
        .multiplier   (multiplier4),
        .multiplicand (multiplicand4),
        .busy         (busy4),
        .done         (done4),
        .productHI    (productHI4),
        .productLO    (productLO4)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Full-width product: sign-extend when signed, then take the low 2W bits.
    function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic [63:0] ae, be;
        ae = s ? {{32{a[31]}}, a} : {32'b0, a};
        be = s ? {{32{b[31]}}, b} : {32'b0, b};
        return ae * be;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Reference model for dut: an accepted op completes N+2 edges later.
    logic        e_busy = 1'b0, e_done = 1'b0;
    logic [63:0] e_prod = '0, p_pend = '0;
    logic        pend = 1'b0;
    int          rem = 0;
    int          ops = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            pend = 1'b0; rem = 0; e_prod = '0; e_done = 1'b0; e_busy = 1'b0;
        end else begin
            e_done = 1'b0;
            if (pend) begin
                rem--;
                if (rem == 0) begin
                    e_done = 1'b1;
                    e_prod = p_pend;
                    pend   = 1'b0;
                end
            end else if (start) begin
                p_pend = ref_prod(multiplicand, multiplier, sign[1]);
                pend   = 1'b1;
                rem    = N1 + 2;
                ops++;
            end
            e_busy = pend;
        end
    end

    always @(negedge clk) begin
        chk("busy", busy, e_busy);
        chk("done", done, e_done);
        chk("productHI", productHI, e_prod[63:32]);
        chk("productLO", productLO, e_prod[31:0]);
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s);
        @(negedge clk);
        multiplicand = a;
        multiplier   = b;
        sign         = {s, 1'b0};
        start        = 1'b1;
    endtask

    // Returns at the negedge where done is seen; noise keeps poking start/operands while busy.
    task automatic await_done(input string nm, input int exp_lat, input bit noise);
        int n;
        n = 0;
        while (1) begin
            @(negedge clk);
            n++;
            if (done || n >= 300) break;
            if (noise) begin
                start        = 1'b1;
                multiplicand = $urandom;
                multiplier   = $urandom;
                sign         = 2'($urandom);
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        chk({nm, "_latency"}, 64'(n - 1), 64'(exp_lat));
    endtask

    task automatic op4(input logic [31:0] a, input logic [31:0] b, input logic s,
                       output logic [63:0] prod, output int lat);
        int n;
        @(negedge clk);
        multiplicand4 = a;
        multiplier4   = b;
        sign4         = {s, 1'b0};
        start4        = 1'b1;
        n = 0;
        while (1) begin
            @(negedge clk);
            n++;
            start4 = 1'b0;
            if (n == 1) chk("dut4_busy", busy4, 1'b1);
            if (done4 || n >= 100) break;
        end
        prod = {productHI4, productLO4};
        lat  = n - 1;
    endtask

    initial begin
        logic [63:0] p;
        int          lat;
        logic [31:0] ra, rb;
        logic        rs;

        reset = 1'b1; start = 1'b0; sign = '0; multiplier = '0; multiplicand = '0;
        start4 = 1'b0; sign4 = '0; multiplier4 = '0; multiplicand4 = '0;
        repeat (2) @(negedge clk);
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_prod", {productHI, productLO}, 64'h0);
        reset = 1'b0;

        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        await_done("t1", N1 + 2, 1'b0);
        chk("t1_prod", {productHI, productLO}, 64'hFFFF_FFFE_0000_0001);

        issue(32'hFFFF_FFFD, 32'd5, 1'b1);
        await_done("t2a", N1 + 2, 1'b0);
        chk("t2a_prod", {productHI, productLO}, 64'hFFFF_FFFF_FFFF_FFF1);
        issue(32'hFFFF_FFF9, 32'hFFFF_FFFA, 1'b1);
        await_done("t2b", N1 + 2, 1'b0);
        chk("t2b_prod", {productHI, productLO}, 64'h0000_0000_0000_002A);
        issue(32'h8000_0000, 32'h8000_0000, 1'b1);
        await_done("t2c", N1 + 2, 1'b0);
        chk("t2c_prod", {productHI, productLO}, 64'h4000_0000_0000_0000);

        issue(32'd100, 32'd200, 1'b0);
        await_done("t3a", N1 + 2, 1'b1);
        chk("t3a_prod", {productHI, productLO}, 64'd20000);
        multiplicand = 32'hFFFF_FFF7;
        multiplier   = 32'd11;
        sign         = 2'b10;
        start        = 1'b1;
        await_done("t3b", N1 + 2, 1'b0);
        chk("t3b_prod", {productHI, productLO}, 64'hFFFF_FFFF_FFFF_FF9D);

        issue(32'd12345, 32'd6789, 1'b0);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("t4_busy", busy, 1'b0);
        chk("t4_done", done, 1'b0);
        chk("t4_prod", {productHI, productLO}, 64'h0);
        @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        issue(32'd6, 32'd7, 1'b1);
        await_done("t4b", N1 + 2, 1'b0);
        chk("t4b_prod", {productHI, productLO}, 64'd42);

        op4(32'h1234_5678, 32'h9ABC_DEF0, 1'b0, p, lat);
        chk("t5_prod", p, 64'h0B00_EA4E_242D_2080);
        chk("t5_latency", 64'(lat), 64'(N4 + 2));
        repeat (300) begin
            ra = pick();
            rb = pick();
            rs = 1'($urandom);
            op4(ra, rb, rs, p, lat);
            chk("dut4_prod", p, ref_prod(ra, rb, rs));
            chk("dut4_latency", 64'(lat), 64'(N4 + 2));
        end

        repeat (30000) begin
            @(negedge clk);
            start        = ($urandom_range(0, 9) < 7);
            multiplicand = pick();
            multiplier   = pick();
            sign         = 2'($urandom);
        end
        @(negedge clk);
        start = 1'b0;
        repeat (40) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
